// File: rtl/track_defs.sv
// Shared constants for the blob tracker: default coordinate width, window
// bounds, growth tolerance, and the layout of the packed box output buses.
package track_defs;

  localparam int unsigned CW         = 11;
  localparam int unsigned MINH       = 50;
  localparam int unsigned MAXH       = 740;
  localparam int unsigned MINV       = 75;
  localparam int unsigned MAXV       = 550;
  localparam int unsigned GAP        = 8;
  localparam int unsigned MIN_PIXELS = 16;

  // Each zone occupies two CW-wide fields on box_h/box_v:
  // field 1 holds left/top, field 0 holds right/bottom.
  localparam int unsigned BOX_FIELDS   = 2;
  localparam int unsigned BOX_LO_FIELD = 0;
  localparam int unsigned BOX_HI_FIELD = 1;

  // Bit offset of a field of a zone on a packed box bus.
  function automatic int unsigned box_ofs(input int unsigned zone,
                                          input int unsigned field,
                                          input int unsigned cw);
    return (zone * BOX_FIELDS + field) * cw;
  endfunction

endpackage

// File: rtl/track_zone.sv
// One blob zone: live bounding box, active flag and match test against the
// current candidate pixel. Optional saturating pixel counter when
// TRACK_PIXCOUNT_EN is defined.
module track_zone #(
  parameter int unsigned W = track_defs::CW,
  parameter int unsigned G = track_defs::GAP
`ifdef TRACK_PIXCOUNT_EN
  , parameter int unsigned MIN_CNT = track_defs::MIN_PIXELS
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         claim_i,
  input  logic [W-1:0] h_i,
  input  logic [W-1:0] v_i,
  output logic         match_c_o,
  output logic         valid_c_o,
  output logic         active_o,
  output logic [W-1:0] left_o,
  output logic [W-1:0] right_o,
  output logic [W-1:0] top_o,
  output logic [W-1:0] bottom_o
`ifdef TRACK_PIXCOUNT_EN
  , output logic [W-1:0] count_o
`endif
);

  localparam int unsigned XW = W + 1;

  logic         active_q, active_d;
  logic [W-1:0] left_q, left_d, right_q, right_d;
  logic [W-1:0] top_q, top_d, bottom_q, bottom_d;
`ifdef TRACK_PIXCOUNT_EN
  logic [W-1:0] count_q, count_d;
`endif

  logic [XW-1:0] h_x, v_x, gap_x;

  assign h_x   = {1'b0, h_i};
  assign v_x   = {1'b0, v_i};
  assign gap_x = XW'(G);

  // Window-with-tolerance test, one bit wider so h+GAP cannot wrap.
  assign match_c_o = active_q
                   && ({1'b0, left_q} <= h_x + gap_x)
                   && (h_x <= {1'b0, right_q} + gap_x)
                   && ({1'b0, top_q} <= v_x + gap_x)
                   && (v_x <= {1'b0, bottom_q} + gap_x);

`ifdef TRACK_PIXCOUNT_EN
  assign valid_c_o = active_q && (count_q >= W'(MIN_CNT));
  assign count_o   = count_q;
`else
  assign valid_c_o = active_q;
`endif

  assign active_o = active_q;
  assign left_o   = left_q;
  assign right_o  = right_q;
  assign top_o    = top_q;
  assign bottom_o = bottom_q;

  // Next-state: frame clear, fresh activation, or growth of the box.
  always_comb begin
    active_d = active_q;
    left_d   = left_q;
    right_d  = right_q;
    top_d    = top_q;
    bottom_d = bottom_q;
`ifdef TRACK_PIXCOUNT_EN
    count_d  = count_q;
`endif
    if (clear_i) begin
      active_d = 1'b0;
      left_d   = '0;
      right_d  = '0;
      top_d    = '0;
      bottom_d = '0;
`ifdef TRACK_PIXCOUNT_EN
      count_d  = '0;
`endif
    end else if (load_i) begin
      active_d = 1'b1;
      left_d   = h_i;
      right_d  = h_i;
      top_d    = v_i;
      bottom_d = v_i;
`ifdef TRACK_PIXCOUNT_EN
      count_d  = W'(1);
`endif
    end else if (claim_i) begin
      left_d   = (h_i < left_q)   ? h_i : left_q;
      right_d  = (h_i > right_q)  ? h_i : right_q;
      top_d    = (v_i < top_q)    ? v_i : top_q;
      bottom_d = (v_i > bottom_q) ? v_i : bottom_q;
`ifdef TRACK_PIXCOUNT_EN
      if (count_q != '1) count_d = count_q + W'(1);
`endif
    end
  end

  // Zone state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      left_q   <= '0;
      right_q  <= '0;
      top_q    <= '0;
      bottom_q <= '0;
`ifdef TRACK_PIXCOUNT_EN
      count_q  <= '0;
`endif
    end else begin
      active_q <= active_d;
      left_q   <= left_d;
      right_q  <= right_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
`ifdef TRACK_PIXCOUNT_EN
      count_q  <= count_d;
`endif
    end
  end

endmodule

// File: rtl/track_blobs.sv
// Multi-zone bright-blob tracker. Candidate pixels are claimed by the lowest
// matching zone, else open the lowest free zone, else raise overflow. The
// frame marker (hcount==0, vcount==0) publishes the live results and clears.
// Optional feature macro: TRACK_PIXCOUNT_EN (per-zone pixel counts).
module track_blobs
  import track_defs::box_ofs, track_defs::BOX_HI_FIELD, track_defs::BOX_LO_FIELD;
#(
  parameter int unsigned NUM_ZONES = 4,
  parameter int unsigned CW        = track_defs::CW,
  parameter int unsigned MINH      = track_defs::MINH,
  parameter int unsigned MAXH      = track_defs::MAXH,
  parameter int unsigned MINV      = track_defs::MINV,
  parameter int unsigned MAXV      = track_defs::MAXV,
  parameter int unsigned GAP       = track_defs::GAP
`ifdef TRACK_PIXCOUNT_EN
  , parameter int unsigned MIN_PIXELS = track_defs::MIN_PIXELS
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CW-1:0]             hcount,
  input  logic [CW-1:0]             vcount,
  input  logic                      is_bright,
  output logic [NUM_ZONES*2*CW-1:0] box_h,
  output logic [NUM_ZONES*2*CW-1:0] box_v,
  output logic [NUM_ZONES-1:0]      box_valid,
  output logic                      overflow,
  output logic                      frame_done
`ifdef TRACK_PIXCOUNT_EN
  , output logic [NUM_ZONES*CW-1:0] pix_count
`endif
);

  localparam int unsigned BW = NUM_ZONES * 2 * CW;

  logic marker_c, cand_c, drop_c;
  logic [NUM_ZONES-1:0] match_c, valid_c, active, claim_c, load_c;
  logic [CW-1:0] left_w [NUM_ZONES];
  logic [CW-1:0] right_w [NUM_ZONES];
  logic [CW-1:0] top_w [NUM_ZONES];
  logic [CW-1:0] bottom_w [NUM_ZONES];

  logic [BW-1:0]        box_h_q, box_h_d, box_v_q, box_v_d;
  logic [NUM_ZONES-1:0] box_valid_q, box_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ovf_live_q, ovf_live_d;
`ifdef TRACK_PIXCOUNT_EN
  logic [CW-1:0]              count_w [NUM_ZONES];
  logic [NUM_ZONES*CW-1:0]    pix_count_q, pix_count_d;
`endif

  // The marker pixel is never a candidate, whatever the window bounds.
  assign marker_c = (hcount == '0) && (vcount == '0);
  assign cand_c   = is_bright && !marker_c
                 && (hcount > CW'(MINH)) && (hcount < CW'(MAXH))
                 && (vcount > CW'(MINV)) && (vcount < CW'(MAXV));

  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    track_zone #(
      .W (CW),
      .G (GAP)
`ifdef TRACK_PIXCOUNT_EN
      , .MIN_CNT (MIN_PIXELS)
`endif
    ) u_zone (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (marker_c),
      .load_i    (load_c[z]),
      .claim_i   (claim_c[z]),
      .h_i       (hcount),
      .v_i       (vcount),
      .match_c_o (match_c[z]),
      .valid_c_o (valid_c[z]),
      .active_o  (active[z]),
      .left_o    (left_w[z]),
      .right_o   (right_w[z]),
      .top_o     (top_w[z]),
      .bottom_o  (bottom_w[z])
`ifdef TRACK_PIXCOUNT_EN
      , .count_o (count_w[z])
`endif
    );
  end

  // Priority cascade: first matching zone claims, else first free zone loads.
  always_comb begin
    logic taken;
    logic free_seen;
    claim_c   = '0;
    load_c    = '0;
    taken     = 1'b0;
    free_seen = 1'b0;
    for (int unsigned i = 0; i < NUM_ZONES; i++) begin
      if (cand_c && match_c[i] && !taken) claim_c[i] = 1'b1;
      taken = taken | match_c[i];
    end
    for (int unsigned i = 0; i < NUM_ZONES; i++) begin
      if (cand_c && !taken && !active[i] && !free_seen) load_c[i] = 1'b1;
      free_seen = free_seen | !active[i];
    end
    drop_c = cand_c && !taken && !free_seen;
  end

  // Published results: hold between markers, snapshot live state at a marker.
  always_comb begin
    box_h_d      = box_h_q;
    box_v_d      = box_v_q;
    box_valid_d  = box_valid_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    ovf_live_d   = ovf_live_q | drop_c;
`ifdef TRACK_PIXCOUNT_EN
    pix_count_d  = pix_count_q;
`endif
    if (marker_c) begin
      frame_done_d = 1'b1;
      overflow_d   = ovf_live_q;
      ovf_live_d   = 1'b0;
      box_valid_d  = valid_c;
      for (int unsigned i = 0; i < NUM_ZONES; i++) begin
        box_h_d[box_ofs(i, BOX_HI_FIELD, CW) +: CW] = active[i] ? left_w[i]   : '0;
        box_h_d[box_ofs(i, BOX_LO_FIELD, CW) +: CW] = active[i] ? right_w[i]  : '0;
        box_v_d[box_ofs(i, BOX_HI_FIELD, CW) +: CW] = active[i] ? top_w[i]    : '0;
        box_v_d[box_ofs(i, BOX_LO_FIELD, CW) +: CW] = active[i] ? bottom_w[i] : '0;
`ifdef TRACK_PIXCOUNT_EN
        pix_count_d[i*CW +: CW] = count_w[i];
`endif
      end
    end
  end

  // Output and live-overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      box_h_q      <= '0;
      box_v_q      <= '0;
      box_valid_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_live_q   <= 1'b0;
`ifdef TRACK_PIXCOUNT_EN
      pix_count_q  <= '0;
`endif
    end else begin
      box_h_q      <= box_h_d;
      box_v_q      <= box_v_d;
      box_valid_q  <= box_valid_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      ovf_live_q   <= ovf_live_d;
`ifdef TRACK_PIXCOUNT_EN
      pix_count_q  <= pix_count_d;
`endif
    end
  end

  assign box_h      = box_h_q;
  assign box_v      = box_v_q;
  assign box_valid  = box_valid_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;
`ifdef TRACK_PIXCOUNT_EN
  assign pix_count  = pix_count_q;
`endif

endmodule

// File: tb/tb_track_blobs.sv
// Testbench for track_blobs: directed scenarios plus random pixel frames,
// checked against a list-of-boxes reference model.
module tb_track_blobs;

  localparam int NZ   = 4;
  localparam int CW   = 11;
  localparam int BW   = NZ * 2 * CW;
  localparam int GAPV = 8;
  localparam int MINP = 16;

  logic          clk;
  logic          reset;
  logic [CW-1:0] hcount, vcount;
  logic          is_bright;
  logic [BW-1:0] box_h, box_v;
  logic [NZ-1:0] box_valid;
  logic          overflow, frame_done;
`ifdef TRACK_PIXCOUNT_EN
  logic [NZ*CW-1:0] pix_count;
`endif

  track_blobs dut (
    .clk        (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .is_bright  (is_bright),
    .box_h      (box_h),
    .box_v      (box_v),
    .box_valid  (box_valid),
    .overflow   (overflow),
    .frame_done (frame_done)
`ifdef TRACK_PIXCOUNT_EN
    , .pix_count (pix_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: blobs open in order, so live zones are a list of boxes.
  typedef struct {int l; int r; int t; int b; int n;} zbox_t;
  zbox_t zq[$];
  bit    ovf_m;

  logic [BW-1:0] pub_h, pub_v;
  logic [NZ-1:0] pub_valid;
  logic          pub_ovf;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic void model_pix(input int h, input int v, input bit b);
    zbox_t z;
    if (!b || (h == 0 && v == 0)) return;
    if (!(h > 50 && h < 740 && v > 75 && v < 550)) return;
    foreach (zq[k]) begin
      z = zq[k];
      if (z.l <= h + GAPV && h <= z.r + GAPV && z.t <= v + GAPV && v <= z.b + GAPV) begin
        if (h < z.l) z.l = h;
        if (h > z.r) z.r = h;
        if (v < z.t) z.t = v;
        if (v > z.b) z.b = v;
        if (z.n < 2047) z.n = z.n + 1;
        zq[k] = z;
        return;
      end
    end
    if (zq.size() < NZ) zq.push_back('{h, h, v, v, 1});
    else ovf_m = 1'b1;
  endfunction

  task automatic drive(input int h, input int v, input bit b);
    @(negedge clk);
    hcount    = CW'(h);
    vcount    = CW'(v);
    is_bright = b;
    @(posedge clk);
    #1;
    model_pix(h, v, b);
  endtask

  task automatic marker(input bit tail);
    logic [BW-1:0] eh, ev;
    logic [NZ-1:0] evd;
`ifdef TRACK_PIXCOUNT_EN
    logic [NZ*CW-1:0] ec;
    ec = '0;
`endif
    chk("hold_box_h", box_h, pub_h);
    chk("hold_valid", box_valid, pub_valid);
    chk("hold_ovf", overflow, pub_ovf);
    eh = '0; ev = '0; evd = '0;
    foreach (zq[k]) begin
      eh[k*2*CW +: 2*CW] = {CW'(zq[k].l), CW'(zq[k].r)};
      ev[k*2*CW +: 2*CW] = {CW'(zq[k].t), CW'(zq[k].b)};
`ifdef TRACK_PIXCOUNT_EN
      evd[k] = (zq[k].n >= MINP);
      ec[k*CW +: CW] = CW'(zq[k].n);
`else
      evd[k] = 1'b1;
`endif
    end
    @(negedge clk);
    hcount    = '0;
    vcount    = '0;
    is_bright = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    chk("box_h", box_h, eh);
    chk("box_v", box_v, ev);
    chk("box_valid", box_valid, evd);
    chk("overflow", overflow, ovf_m);
    chk("frame_done", frame_done, 1'b1);
`ifdef TRACK_PIXCOUNT_EN
    chk("pix_count", pix_count, ec);
`endif
    pub_h = eh; pub_v = ev; pub_valid = evd; pub_ovf = ovf_m;
    zq.delete();
    ovf_m = 1'b0;
    if (tail) begin
      drive(5, 5, 1'b1);
      chk("done_pulse", frame_done, 1'b0);
    end
  endtask

  task automatic do_reset(input int h, input int v, input bit b);
    @(negedge clk);
    reset     = 1'b1;
    hcount    = CW'(h);
    vcount    = CW'(v);
    is_bright = b;
    @(posedge clk);
    #1;
    chk("rst_box_h", box_h, '0);
    chk("rst_box_v", box_v, '0);
    chk("rst_valid", box_valid, '0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_done", frame_done, 1'b0);
`ifdef TRACK_PIXCOUNT_EN
    chk("rst_pix_count", pix_count, '0);
`endif
    reset = 1'b0;
    zq.delete();
    ovf_m = 1'b0;
    pub_h = '0; pub_v = '0; pub_valid = '0; pub_ovf = 1'b0;
  endtask

  task automatic square(input int h0, input int v0);
    for (int v = v0; v < v0 + 3; v++)
      for (int h = h0; h < h0 + 3; h++) drive(h, v, 1'b1);
  endtask

  task automatic rand_frame();
    int nc, np, c, h, v;
    int ch[6];
    int cv[6];
    nc = int'($urandom_range(1, 6));
    for (int i = 0; i < nc; i++) begin
      ch[i] = int'($urandom_range(40, 760));
      cv[i] = int'($urandom_range(60, 570));
    end
    np = int'($urandom_range(10, 60));
    for (int p = 0; p < np; p++) begin
      c = int'($urandom_range(0, nc - 1));
      h = ch[c] + int'($urandom_range(0, 24)) - 12;
      v = cv[c] + int'($urandom_range(0, 24)) - 12;
      drive(h, v, $urandom_range(0, 9) < 8);
    end
    marker(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; is_bright = 1'b1;
    ovf_m = 1'b0;
    // Reset wins over a simultaneous marker.
    do_reset(0, 0, 1'b1);
    // Empty frame.
    marker(1'b1);

    // Single 3x3 square.
    drive(90, 190, 1'b0);
    square(100, 200);
    marker(1'b1);
    chk("sq_box_h", box_h[2*CW-1:0], {11'd100, 11'd102});
    chk("sq_box_v", box_v[2*CW-1:0], {11'd200, 11'd202});
`ifndef TRACK_PIXCOUNT_EN
    chk("sq_valid", box_valid, 4'b0001);
`endif

    // Two squares on the same rows stay separate.
    for (int v = 200; v < 203; v++) begin
      for (int h = 100; h < 103; h++) drive(h, v, 1'b1);
      for (int h = 400; h < 403; h++) drive(h, v, 1'b1);
    end
    marker(1'b1);
    chk("two_ovf", overflow, 1'b0);

    // Five dots with four zones: overflow, then a clean empty frame.
    for (int i = 1; i <= 5; i++) drive(i * 100, 300, 1'b1);
    marker(1'b1);
    chk("five_ovf", overflow, 1'b1);
`ifndef TRACK_PIXCOUNT_EN
    chk("five_valid", box_valid, 4'b1111);
`endif
    marker(1'b1);
    chk("empty_valid", box_valid, 4'b0000);

    // Window bounds are exclusive.
    drive(50, 300, 1'b1);
    drive(740, 300, 1'b1);
    drive(300, 75, 1'b1);
    drive(300, 550, 1'b1);
    marker(1'b1);
    chk("bounds_valid", box_valid, 4'b0000);

    // GAP edge: 8 apart merges, 9 apart splits.
    drive(100, 300, 1'b1);
    drive(108, 300, 1'b1);
    marker(1'b1);
    chk("gap8_box_h", box_h[2*CW-1:0], {11'd100, 11'd108});
    chk("gap8_zone1", box_h[4*CW-1:2*CW], '0);
    drive(100, 300, 1'b1);
    drive(109, 300, 1'b1);
    marker(1'b1);
    chk("gap9_zone1", box_h[4*CW-1:2*CW], {11'd109, 11'd109});

    // Back-to-back markers.
    square(300, 300);
    marker(1'b0);
    marker(1'b1);

    // Reset mid-frame with a candidate present, then a fresh frame.
    square(200, 200);
    for (int i = 1; i <= 5; i++) drive(i * 100, 400, 1'b1);
    do_reset(250, 250, 1'b1);
    square(600, 300);
    marker(1'b1);

    for (int f = 0; f < 30; f++) rand_frame();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
